demux4_buf: RTL
===============

Name: demux4_buf

Overview:
- Registered 1-to-4 demultiplexer: routes one WIDTH-bit word from a single valid/ready source to one of four destination channels, or to all four in broadcast mode.
- Each channel holds its word in a one-entry output buffer until that channel's consumer accepts it.
- Inverse of the 4:1 select path. Used on datapath write-back and fan-out, where one producer feeds four sinks (e.g. register-bank write ports).
- Channel encoding matches the mux4 select convention: sel1 is the LSB, sel2 is the MSB.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in  input  WIDTH  source data word.
- in_valid  input  1  source offers a word this cycle.
- in_ready  output  1  block accepts the offered word this cycle.
- sel1  input  1  destination select, LSB.
- sel2  input  1  destination select, MSB.
- bcast  input  1  when 1, the word goes to all four channels and sel1/sel2 are ignored.
- out1, out2, out3, out4  output  WIDTH each  channel data registers.
- out_valid  output  4  bit k-1 = channel k holds a word.
- out_ready  input  4  bit k-1 = consumer k accepts this cycle.

Behaviour:
- Channel index = {sel2, sel1}: 00 -> out1, 01 -> out2, 10 -> out3, 11 -> out4.
- Reset: when rst_n=0 at a rising clk edge:
  - out_valid = 4'b0000.
  - out1..out4 = 0.
  - Any word in flight is discarded.
  - Reset takes priority over every concurrent transfer.
- Per-channel free condition: free[k] = ~out_valid[k] | out_ready[k]. A channel can accept a new word in the same cycle its current word drains.
- in_ready is combinational from free, sel1, sel2, bcast, with no dependence on in_valid:
  - bcast=0: in_ready = free[{sel2,sel1}].
  - bcast=1: in_ready = AND of all free[k]. Broadcast is all-or-nothing; there are never partial writes.
- Accept = in_valid & in_ready. On accept, each targeted channel loads `in` and sets out_valid[k]=1. Latency is 1 cycle: the word is visible on outK the cycle after accept.
- Drain: out_valid[k] & out_ready[k] with no new load into k -> out_valid[k]=0. outK retains its stale value.
- Simultaneous drain and load on the same channel -> outK takes the new word and out_valid[k] stays 1. There is no bubble.
- Untargeted channels are unaffected by an accept.
- While out_valid[k]=1 and no load occurs, outK is stable, regardless of out_ready.
- in_valid=0: no state change except drains.
- sel1, sel2, bcast are sampled only in the accept cycle. Changing them while in_valid=1 and in_ready=0 is legal; the block uses whatever values are present in the accept cycle.
- Each channel operates independently. A stalled channel must not block words destined for other channels.

Decomposition:
- Shared include header:
  - channel index defines: CH1=2'b00, CH2=2'b01, CH3=2'b10, CH4=2'b11.
  - default WIDTH define.
- One sub-module, demux_slot (WIDTH):
  - single channel buffer with ports clk, rst_n, load, din, ready, dout, valid, free.
  - instantiated four times.
- The top level holds the select decode, the broadcast AND, and in_ready.

Test Plan:
1. Reset then idle: hold rst_n=0 for 2 cycles with in_valid=1 and bcast=1 -> out_valid=0000, out1..out4=0, no load. After release, in_ready=1.
2. Routing: send 8'hA1 with sel2,sel1 = 00, then 8'hB2/01, 8'hC3/10, 8'hD4/11, with out_ready=0000 -> out_valid=1111 and out1..out4=A1,B2,C3,D4, each visible 1 cycle after its accept. A fifth word to 01 sees in_ready=0.
3. Back-to-back on one channel: out_ready[0]=1, stream 8'h10, 11, 12 to channel 00 on consecutive cycles -> in_ready stays 1. out1 shows 10, 11, 12 on consecutive cycles and out_valid[0] stays 1.
4. Broadcast blocking: out_valid=0100 with out_ready=0000, send 8'h5A with bcast=1 -> in_ready=0 and no channel changes. Raise out_ready[2] -> accepted the same cycle. Next cycle out1..out4=5A and out_valid=1111.
5. Independence: channel 4 full and stalled, word 8'h77 to channel 00 -> accepted immediately and out1=77. Channel 4 is unchanged.
6. Reset mid-operation: out_valid=1011 with in_valid=1 targeting channel 01, assert rst_n=0 for 1 cycle -> out_valid=0000 and out1..out4=0. The in-flight word is not loaded.

Source files
------------

// File: rtl/demux4_buf_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
// Channel codes follow the mux4 select convention {sel2, sel1}.
package demux4_buf_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] CH1 = 2'b00;
  localparam logic [1:0] CH2 = 2'b01;
  localparam logic [1:0] CH3 = 2'b10;
  localparam logic [1:0] CH4 = 2'b11;

  function automatic logic [3:0] ch_onehot(
    input logic [1:0] idx
  );
    logic [3:0] oh;
    oh = 4'b0000;
    unique case (idx)
      CH1: oh = 4'b0001;
      CH2: oh = 4'b0010;
      CH3: oh = 4'b0100;
      CH4: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux4_buf_slot.sv
// One-entry channel buffer: holds a word until its consumer takes it.
// A load in the same cycle as a drain replaces the word with no bubble.
module demux_slot
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             free
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~ready;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;
  assign free  = ~valid_q | ready;

endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer with per-channel output buffers.
// Broadcast is all-or-nothing: it waits until every channel is free.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             bcast,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  logic [3:0]       free_w;
  logic [3:0]       sel_oh;
  logic [3:0]       tgt_w;
  logic [3:0]       load_w;
  logic             accept;
  logic [WIDTH-1:0] data_w [4];

  assign sel_oh   = ch_onehot({sel2, sel1});
  assign tgt_w    = bcast ? 4'b1111 : sel_oh;
  assign in_ready = bcast ? (&free_w)
                          : (|(free_w & sel_oh));
  assign accept   = in_valid & in_ready;
  assign load_w   = {4{accept}} & tgt_w;

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load_w[k]),
      .din  (in),
      .ready(out_ready[k]),
      .dout (data_w[k]),
      .valid(out_valid[k]),
      .free (free_w[k])
    );
  end

  assign out1 = data_w[0];
  assign out2 = data_w[1];
  assign out3 = data_w[2];
  assign out4 = data_w[3];

endmodule
